// File: rtl/load_sequencer_if.sv
// load_sequencer_if: request, memory-read and result signals of the load sequencer.
interface load_sequencer_if;
  logic req_valid_i;
  logic req_ready_o;
  logic [31:0] req_addr_i;
  logic [2:0] width_src_i;
  logic flush_i;
  logic mem_req_o;
  logic [31:0] mem_addr_o;
  logic mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic result_valid_o;
  logic [31:0] result_o;
  logic fault_o;
  modport slave (
    input req_valid_i, req_addr_i, width_src_i, flush_i, mem_ack_i, mem_rdata_i,
    output req_ready_o, mem_req_o, mem_addr_o, result_valid_o, result_o, fault_o
  );
  modport master (
    output req_valid_i, req_addr_i, width_src_i, flush_i, mem_ack_i, mem_rdata_i,
    input req_ready_o, mem_req_o, mem_addr_o, result_valid_o, result_o, fault_o
  );
endinterface

// File: rtl/load_sequencer.sv
// load_sequencer: issues one or two word reads per load, merges and extends the result.
// Define MISALIGNED_SPLIT_EN to fetch misaligned loads as two words; otherwise they fault.
module load_sequencer (
  input logic clk_i,
  input logic reset_n_i,
  load_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD0, RD1, DONE} state_t;
  state_t state, state_nx;
  logic ready, fault, kill, accept, bad, killed, mem_busy;
  logic [1:0] off;
  logic [2:0] width;
  logic [31:0] addr, lo, result, merged, ext;
  logic [63:0] wide, shifted;
  function automatic logic is_split(input logic [2:0] w, input logic [1:0] o);
    return (w[1:0] == 2'b00 && o != 2'd0) || (w[1:0] == 2'b10 && o == 2'd3);
  endfunction
  always_comb begin
    accept = bus.req_valid_i & ready;
    killed = kill | bus.flush_i;
    mem_busy = state == RD0 || state == RD1;
`ifdef MISALIGNED_SPLIT_EN
    bad = !(bus.width_src_i inside {3'b000, 3'b010, 3'b110, 3'b001, 3'b101});
`else
    bad = !(bus.width_src_i inside {3'b000, 3'b010, 3'b110, 3'b001, 3'b101}) ||
          is_split(bus.width_src_i, bus.req_addr_i[1:0]);
`endif
    // the final beat's data is used straight off the bus so the result is registered on the ack edge
    wide = state == RD1 ? {bus.mem_rdata_i, lo} : {32'd0, bus.mem_rdata_i};
    shifted = wide >> {off, 3'b000};
    merged = shifted[31:0];
    ext = width[1:0] == 2'b01 ? {{24{~width[2] & merged[7]}}, merged[7:0]} :
          width[1:0] == 2'b10 ? {{16{~width[2] & merged[15]}}, merged[15:0]} : merged;
    state_nx = state;
    case (state)
      IDLE: state_nx = accept && !bad ? RD0 : IDLE;
`ifdef MISALIGNED_SPLIT_EN
      RD0: state_nx = !bus.mem_ack_i ? RD0 : killed ? IDLE : is_split(width, off) ? RD1 : DONE;
      RD1: state_nx = !bus.mem_ack_i ? RD1 : killed ? IDLE : DONE;
`else
      RD0: state_nx = !bus.mem_ack_i ? RD0 : killed ? IDLE : DONE;
      RD1: state_nx = IDLE;
`endif
      DONE: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      ready <= 1'b0;
      fault <= 1'b0;
      kill <= 1'b0;
      off <= '0;
      width <= '0;
      addr <= '0;
      lo <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      ready <= state_nx == IDLE;
      fault <= accept && bad;
      kill <= mem_busy && state_nx == state && killed;
      if (accept) begin
        addr <= {bus.req_addr_i[31:2], 2'b00};
        off <= bus.req_addr_i[1:0];
        width <= bus.width_src_i;
      end
      if (state == RD0 && bus.mem_ack_i) lo <= bus.mem_rdata_i;
      if (state == RD0 && state_nx == RD1) addr <= addr + 32'd4;
      if (state_nx == DONE) result <= ext;
    end
  end
  assign bus.req_ready_o = ready;
  assign bus.mem_req_o = mem_busy;
  assign bus.mem_addr_o = addr;
  assign bus.result_valid_o = state == DONE;
  assign bus.result_o = result;
  assign bus.fault_o = fault;
endmodule
